// File: rtl/pj_fetch_queue_pkg.sv
// Shared constants and small lane helpers for the FE->BE multi-lane fetch queue.
// Lane helpers take a 4-bit mask because the queue supports at most four lanes.
package pj_fetch_queue_pkg;

  localparam int DECODED_INSTRUCTION_WIDTH = 32;
  localparam int FETCH_QUEUE_ELS           = 32;
  localparam int FETCH_QUEUE_LANES         = 2;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // True when the set bits form a run starting at lane 0 (including the empty mask).
  function automatic logic contiguous4(input logic [3:0] v);
    return (v & (v + 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/pj_fetch_queue_if.sv
// Enqueue/dequeue bundle between fe_top (producer), be_top (consumer) and the fetch queue.
// master = fe/be side driving valids, data and yumi; slave = the queue itself.
interface pj_fetch_queue_if #(
  parameter int WIDTH_P = 32,
  parameter int LANES_P = 2,
  parameter int ELS_P   = 32
);
  localparam int YUMI_W = $clog2(LANES_P + 1);
  localparam int CNT_W  = $clog2(ELS_P + 1);

  logic [LANES_P-1:0]         enq_v_i;
  logic [LANES_P*WIDTH_P-1:0] enq_data_i;
  logic                       enq_ready_o;
  logic [LANES_P-1:0]         deq_v_o;
  logic [LANES_P*WIDTH_P-1:0] deq_data_o;
  logic [YUMI_W-1:0]          deq_yumi_cnt_i;
  logic [CNT_W-1:0]           count_o;

  modport master (
    output enq_v_i, enq_data_i, deq_yumi_cnt_i,
    input  enq_ready_o, deq_v_o, deq_data_o, count_o
  );

  modport slave (
    input  enq_v_i, enq_data_i, deq_yumi_cnt_i,
    output enq_ready_o, deq_v_o, deq_data_o, count_o
  );
endinterface

// File: rtl/pj_fetch_queue_mem.sv
// ELS_P x WIDTH_P register file: LANES_P writes at wptr+k, LANES_P async reads at rptr+k.
// Latency: write visible after the edge, read combinational; no backpressure (caller gates we_i).
module pj_fetch_queue_mem #(
  parameter int WIDTH_P = 32,
  parameter int ELS_P   = 32,
  parameter int LANES_P = 2,
  localparam int PTR_W  = $clog2(ELS_P)
) (
  input  logic                       clk_i,
  input  logic [LANES_P-1:0]         we_i,
  input  logic [PTR_W-1:0]           wptr_i,
  input  logic [LANES_P*WIDTH_P-1:0] wdata_i,
  input  logic [PTR_W-1:0]           rptr_i,
  output logic [LANES_P*WIDTH_P-1:0] rdata_o
);

  logic [WIDTH_P-1:0] mem [ELS_P];

  // Pointer addition wraps naturally because ELS_P is a power of two.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES_P; k++) begin
      if (we_i[k]) mem[wptr_i + PTR_W'(k)] <= wdata_i[k*WIDTH_P +: WIDTH_P];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < LANES_P; k++) begin
      rdata_o[k*WIDTH_P +: WIDTH_P] = mem[rptr_i + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/pj_fetch_queue.sv
// Multi-lane FE->BE decoupling queue with mispredict flush; optional stats via PJ_FETCH_QUEUE_STATS_EN.
// Latency: 1 cycle enq->head, combinational head read; enq_ready drops unless LANES_P slots free.
module pj_fetch_queue
  import pj_fetch_queue_pkg::*;
#(
  parameter int WIDTH_P = DECODED_INSTRUCTION_WIDTH,
  parameter int ELS_P   = FETCH_QUEUE_ELS,
  parameter int LANES_P = FETCH_QUEUE_LANES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic flush_i,
  pj_fetch_queue_if.slave q
`ifdef PJ_FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_cnt_o
`endif
);

  localparam int PTR_W  = $clog2(ELS_P);
  localparam int CNT_W  = $clog2(ELS_P + 1);
  localparam int YUMI_W = $clog2(LANES_P + 1);

  logic [PTR_W-1:0]   rptr, wptr;
  logic [CNT_W-1:0]   count;
  logic               enq_ready;
  logic [LANES_P-1:0] enq_fire;
  logic [YUMI_W-1:0]  n_enq, n_deq;

  // Ready looks only at the registered count, so a same-cycle dequeue never frees room.
  assign enq_ready = (count <= CNT_W'(ELS_P - LANES_P)) & ~reset_i;
  assign enq_fire  = q.enq_v_i & {LANES_P{enq_ready & ~flush_i}};
  assign n_enq     = YUMI_W'(popcount4(4'(enq_fire)));

  // An over-consume is clamped to what is actually held so count bottoms out at 0.
  always_comb begin
    n_deq = q.deq_yumi_cnt_i;
    if (CNT_W'(q.deq_yumi_cnt_i) > count) n_deq = YUMI_W'(count);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PTR_W'(n_enq);
      rptr  <= rptr + PTR_W'(n_deq);
      count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  always_comb begin
    q.deq_v_o = '0;
    for (int k = 0; k < LANES_P; k++) begin
      q.deq_v_o[k] = (count > CNT_W'(k)) & ~reset_i;
    end
  end

  assign q.enq_ready_o = enq_ready;
  assign q.count_o     = count;

  pj_fetch_queue_mem #(
    .WIDTH_P(WIDTH_P),
    .ELS_P  (ELS_P),
    .LANES_P(LANES_P)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (enq_fire),
    .wptr_i (wptr),
    .wdata_i(q.enq_data_i),
    .rptr_i (rptr),
    .rdata_o(q.deq_data_o)
  );

`ifdef PJ_FETCH_QUEUE_STATS_EN
  // Flush deliberately leaves these alone; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cycles_o <= '0;
      flush_cnt_o    <= '0;
    end else begin
      if ((|q.enq_v_i) && !enq_ready && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + 32'd1;
      if (flush_i && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (contiguous4(4'(q.enq_v_i)))
        else $error("pj_fetch_queue: non-contiguous enq_v_i %b", q.enq_v_i);
      assert (3'(q.deq_yumi_cnt_i) <= popcount4(4'(q.deq_v_o)))
        else $error("pj_fetch_queue: yumi %0d exceeds valid heads", q.deq_yumi_cnt_i);
      assert (count <= CNT_W'(ELS_P))
        else $error("pj_fetch_queue: count %0d above capacity", count);
    end
  end
`endif

endmodule

// File: tb/tb_pj_fetch_queue.sv
// Bench for pj_fetch_queue (ELS_P=8, LANES_P=2): directed vectors plus a random run against a queue model.
// Optional stats checks compile in with PJ_FETCH_QUEUE_STATS_EN.
module tb_pj_fetch_queue;

  localparam int W = 16;
  localparam int E = 8;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst;
  logic fl;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pj_fetch_queue_if #(.WIDTH_P(W), .LANES_P(L), .ELS_P(E)) qif ();

`ifdef PJ_FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_cnt;
`endif

  pj_fetch_queue #(.WIDTH_P(W), .ELS_P(E), .LANES_P(L)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .flush_i(fl),
    .q      (qif)
`ifdef PJ_FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles_o(stall_cycles),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a plain FIFO of entries plus the two stats counters.
  logic [W-1:0] mq[$];
  logic [31:0]  m_stall = '0;
  logic [15:0]  m_flush = '0;

  always @(posedge clk) begin : model
    int  sz;
    int  nd;
    logic rdy;
    sz  = mq.size();
    rdy = (sz <= E - L) && !rst;
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if ((|qif.enq_v_i) && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (fl && m_flush != 16'hFFFF) m_flush = m_flush + 1;
    end
    if (rst || fl) mq.delete();
    else begin
      nd = int'(qif.deq_yumi_cnt_i);
      if (nd > sz) nd = sz;
      repeat (nd) void'(mq.pop_front());
      if (rdy)
        for (int k = 0; k < L; k++)
          if (qif.enq_v_i[k]) mq.push_back(qif.enq_data_i[k*W +: W]);
    end
  end

  always @(negedge clk) begin : compare
    int sz;
    if (chk_en) begin
      sz = mq.size();
      if (rst) begin
        chk("rst_enq_ready", 64'(qif.enq_ready_o), 64'd0);
        chk("rst_deq_v", 64'(qif.deq_v_o), 64'd0);
      end else begin
        chk("enq_ready", 64'(qif.enq_ready_o), 64'(sz <= E - L));
        chk("count", 64'(qif.count_o), 64'(sz));
        for (int k = 0; k < L; k++) begin
          chk("deq_v", 64'(qif.deq_v_o[k]), 64'(sz > k));
          if (sz > k) chk("deq_data", 64'(qif.deq_data_o[k*W +: W]), 64'(mq[k]));
        end
      end
`ifdef PJ_FETCH_QUEUE_STATS_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end
  end

  task automatic cyc(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic [1:0] y, input logic f);
    qif.enq_v_i        = v;
    qif.enq_data_i     = {d1, d0};
    qif.deq_yumi_cnt_i = y;
    fl                 = f;
    @(posedge clk);
    #1;
    qif.enq_v_i        = '0;
    qif.deq_yumi_cnt_i = '0;
    fl                 = 1'b0;
  endtask

  function automatic logic [W-1:0] lane(input int k);
    return qif.deq_data_o[k*W +: W];
  endfunction

  initial begin : stim
    int sz, r, ymax;
    logic [1:0] v, y;
    rst = 1'b1;
    fl  = 1'b0;
    qif.enq_v_i        = 2'b11;
    qif.enq_data_i     = {16'hBBBB, 16'hAAAA};
    qif.deq_yumi_cnt_i = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("hold_rst_ready", 64'(qif.enq_ready_o), 64'd0);
    chk("hold_rst_deq_v", 64'(qif.deq_v_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_count", 64'(qif.count_o), 64'd0);
    chk("post_rst_ready", 64'(qif.enq_ready_o), 64'd1);

    // Two lanes in, both visible next cycle.
    cyc(2'b11, 16'hAAAA, 16'hBBBB, 2'd0, 1'b0);
    chk("t1_deq_v", 64'(qif.deq_v_o), 64'd3);
    chk("t1_lane0", 64'(lane(0)), 64'hAAAA);
    chk("t1_lane1", 64'(lane(1)), 64'hBBBB);
    chk("t1_count", 64'(qif.count_o), 64'd2);
    chk("t1_model_size", 64'(mq.size()), 64'd2);

    // Fill to 7: ready drops, a blocked enqueue is ignored, one yumi reopens it.
    cyc(2'b00, 16'h0, 16'h0, 2'd0, 1'b1);
    cyc(2'b11, 16'hD000, 16'hD001, 2'd0, 1'b0);
    cyc(2'b11, 16'hD002, 16'hD003, 2'd0, 1'b0);
    cyc(2'b11, 16'hD004, 16'hD005, 2'd0, 1'b0);
    chk("t2_ready_at6", 64'(qif.enq_ready_o), 64'd1);
    cyc(2'b01, 16'hD006, 16'h0, 2'd0, 1'b0);
    chk("t2_count7", 64'(qif.count_o), 64'd7);
    chk("t2_ready_at7", 64'(qif.enq_ready_o), 64'd0);
    cyc(2'b11, 16'hEEEE, 16'hEEEE, 2'd1, 1'b0);
    chk("t2_count6", 64'(qif.count_o), 64'd6);
    chk("t2_ready_again", 64'(qif.enq_ready_o), 64'd1);
    chk("t2_head", 64'(lane(0)), 64'hD001);

    // wptr=7: X lands in slot 7, Y in slot 0; then drain across the wrap.
    cyc(2'b11, 16'h7777, 16'h0F0F, 2'd0, 1'b0);
    chk("t3_count8", 64'(qif.count_o), 64'd8);
    cyc(2'b00, 16'h0, 16'h0, 2'd2, 1'b0);
    cyc(2'b00, 16'h0, 16'h0, 2'd2, 1'b0);
    cyc(2'b00, 16'h0, 16'h0, 2'd2, 1'b0);
    chk("t3_wrap_lane0", 64'(lane(0)), 64'h7777);
    chk("t3_wrap_lane1", 64'(lane(1)), 64'h0F0F);
    cyc(2'b00, 16'h0, 16'h0, 2'd2, 1'b0);
    chk("t3_empty_deq_v", 64'(qif.deq_v_o), 64'd0);

    // Flush beats a same-cycle enqueue and yumi.
    cyc(2'b11, 16'h1111, 16'h2222, 2'd0, 1'b0);
    cyc(2'b11, 16'h3333, 16'h4444, 2'd0, 1'b0);
    cyc(2'b01, 16'h5555, 16'h0, 2'd0, 1'b0);
    chk("t4_count5", 64'(qif.count_o), 64'd5);
    cyc(2'b11, 16'h6666, 16'h6666, 2'd2, 1'b1);
    chk("t4_count", 64'(qif.count_o), 64'd0);
    chk("t4_deq_v", 64'(qif.deq_v_o), 64'd0);
    chk("t4_ready", 64'(qif.enq_ready_o), 64'd1);

    // Simultaneous enq and deq at count=1.
    cyc(2'b01, 16'h9999, 16'h0, 2'd0, 1'b0);
    cyc(2'b01, 16'h2A2A, 16'h0, 2'd1, 1'b0);
    chk("t5_count", 64'(qif.count_o), 64'd1);
    chk("t5_head", 64'(lane(0)), 64'h2A2A);
    chk("t5_deq_v", 64'(qif.deq_v_o), 64'd1);

    for (int i = 0; i < 10000; i++) begin
      sz   = mq.size();
      r    = int'($urandom_range(0, 2));
      v    = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      ymax = (sz < L) ? sz : L;
      y    = 2'($urandom_range(0, ymax));
      rst  = ($urandom_range(0, 999) == 0);
      cyc(v, 16'($urandom), 16'($urandom), y, $urandom_range(0, 39) == 0);
      rst  = 1'b0;
    end

`ifdef PJ_FETCH_QUEUE_STATS_EN
    rst = 1'b1;
    cyc(2'b00, 16'h0, 16'h0, 2'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(2'b11, 16'(i), 16'(i + 100), 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(2'b11, 16'hDEAD, 16'hBEEF, 2'd0, 1'b0);
    cyc(2'b00, 16'h0, 16'h0, 2'd0, 1'b1);
    cyc(2'b00, 16'h0, 16'h0, 2'd0, 1'b1);
    chk("stats_stall", 64'(stall_cycles), 64'd5);
    chk("stats_flush", 64'(flush_cnt), 64'd2);
    rst = 1'b1;
    cyc(2'b00, 16'h0, 16'h0, 2'd0, 1'b0);
    rst = 1'b0;
    chk("stats_rst_stall", 64'(stall_cycles), 64'd0);
    chk("stats_rst_flush", 64'(flush_cnt), 64'd0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
